// File: rtl/handshake_pkg.sv
// Shared types and helpers for the multi-channel ready/valid transmit path.
// Build option: HANDSHAKE_TX_STATS_EN (see handshake_channel_tx) enables per-channel ack counters.
package handshake_pkg;

   // Occupancy of the transmit skid buffer: nothing, presented head only, head plus skid entry.
   typedef enum logic [1:0] {
      TX_EMPTY = 2'd0,
      TX_HEAD  = 2'd1,
      TX_FULL  = 2'd2
   } tx_state_e;

   // Width of the channel index. A single-channel build still carries one (ignored) bit.
   function automatic int ch_width(input int n);
      if (n >= 2) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

   // The {channel, data} item struct depends on module parameters, so it is
   // declared inside handshake_channel_tx as tx_item_t.

endpackage

// File: rtl/handshake_skid_buffer.sv
// Generic 2-entry registered ready/valid slice.
// up_ready, dn_valid and dn_data all come straight from flops; the skid entry
// absorbs the item accepted in the cycle the downstream side stalls, which keeps
// full throughput without a combinational ready path.
module handshake_skid_buffer
   import handshake_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] up_data,
   input  logic             up_valid,
   output logic             up_ready,
   output logic [WIDTH-1:0] dn_data,
   output logic             dn_valid,
   input  logic             dn_ready
);

   tx_state_e        state_r;
   tx_state_e        state_nxt_s;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] head_nxt_s;
   logic [WIDTH-1:0] skid_r;
   logic [WIDTH-1:0] skid_nxt_s;
   logic             ready_r;
   logic             ready_nxt_s;
   logic             valid_r;
   logic             valid_nxt_s;
   logic             accept_s;
   logic             ack_s;

   assign accept_s = up_valid & ready_r;
   assign ack_s    = valid_r & dn_ready;

   assign up_ready = ready_r;
   assign dn_valid = valid_r;
   assign dn_data  = head_r;

   // State and storage registers; reset empties the buffer and clears the head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= TX_EMPTY;
         head_r  <= {WIDTH{1'b0}};
         skid_r  <= {WIDTH{1'b0}};
         ready_r <= 1'b1;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         head_r  <= head_nxt_s;
         skid_r  <= skid_nxt_s;
         ready_r <= ready_nxt_s;
         valid_r <= valid_nxt_s;
      end
   end

   // Next occupancy and data movement; ready/valid are precomputed from the next state.
   always_comb begin
      state_nxt_s = state_r;
      head_nxt_s  = head_r;
      skid_nxt_s  = skid_r;
      case (state_r)
         TX_EMPTY: begin
            if (accept_s) begin
               head_nxt_s  = up_data;
               state_nxt_s = TX_HEAD;
            end else begin
               state_nxt_s = TX_EMPTY;
            end
         end
         TX_HEAD: begin
            if (accept_s && ack_s) begin
               head_nxt_s  = up_data;
               state_nxt_s = TX_HEAD;
            end else if (accept_s) begin
               skid_nxt_s  = up_data;
               state_nxt_s = TX_FULL;
            end else if (ack_s) begin
               state_nxt_s = TX_EMPTY;
            end else begin
               state_nxt_s = TX_HEAD;
            end
         end
         TX_FULL: begin
            // up_ready is low here, so only the drain of the head can happen.
            if (ack_s) begin
               head_nxt_s  = skid_r;
               state_nxt_s = TX_HEAD;
            end else begin
               state_nxt_s = TX_FULL;
            end
         end
         default: begin
            state_nxt_s = TX_EMPTY;
         end
      endcase
      ready_nxt_s = (state_nxt_s != TX_FULL);
      valid_nxt_s = (state_nxt_s != TX_EMPTY);
   end

endmodule

// File: rtl/handshake_channel_tx.sv
// Transmit end of a multi-channel ready/valid link: one upstream (data, channel)
// stream fanned out onto a shared data bus with a valid/ready pair per channel.
// Items leave strictly in arrival order (head-of-line blocking is intended).
// Build option: define HANDSHAKE_TX_STATS_EN to build saturating per-channel ack
// counters on stat_ack; otherwise stat_ack is tied to zero (same port list).
module handshake_channel_tx
   import handshake_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_CHANNEL = 1,
   parameter int STAT_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_WIDTH-1:0]             in_data,
   input  logic [ch_width(NUM_CHANNEL)-1:0]  in_channel,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic [NUM_CHANNEL-1:0]            out_valid,
   input  logic [NUM_CHANNEL-1:0]            out_ready,
   output logic                              err_drop,
   output logic [NUM_CHANNEL*STAT_WIDTH-1:0] stat_ack
);

   localparam int CH_W = ch_width(NUM_CHANNEL);

   typedef struct packed {
      logic [CH_W-1:0]       channel;
      logic [DATA_WIDTH-1:0] data;
   } tx_item_t;

   localparam int ITEM_W = $bits(tx_item_t);

   tx_item_t               up_item_s;
   tx_item_t               head_item_s;
   logic                   in_range_s;
   logic                   buf_valid_s;
   logic                   head_valid_s;
   logic                   head_ack_s;
   logic [NUM_CHANNEL-1:0] sel_s;
   logic                   err_drop_r;

   // Range check only exists when the index width can encode unused channel numbers.
   generate
      if ((NUM_CHANNEL > 1) && ((1 << CH_W) > NUM_CHANNEL)) begin : g_range_chk
         assign in_range_s = (32'(in_channel) < 32'(NUM_CHANNEL));
      end else begin : g_range_all
         assign in_range_s = 1'b1;
      end
   endgenerate

   // A single-channel link ignores in_channel entirely.
   assign up_item_s.channel = (NUM_CHANNEL > 1) ? in_channel : {CH_W{1'b0}};
   assign up_item_s.data    = in_data;

   // Out-of-range items are still accepted (in_ready is honoured) but never enter the buffer.
   assign buf_valid_s = in_valid & in_range_s;

   handshake_skid_buffer #(
      .WIDTH (ITEM_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .up_data  (up_item_s),
      .up_valid (buf_valid_s),
      .up_ready (in_ready),
      .dn_data  (head_item_s),
      .dn_valid (head_valid_s),
      .dn_ready (head_ack_s)
   );

   // One-hot channel select of the buffered head; all operands are flop outputs.
   always_comb begin
      sel_s = {NUM_CHANNEL{1'b0}};
      for (int c = 0; c < NUM_CHANNEL; c++) begin
         if (NUM_CHANNEL == 1) begin
            sel_s[c] = head_valid_s;
         end else begin
            sel_s[c] = head_valid_s && (head_item_s.channel == CH_W'(c));
         end
      end
   end

   assign out_valid  = sel_s;
   assign out_data   = head_item_s.data;
   // Ready bits of channels that are not being presented are ignored.
   assign head_ack_s = |(sel_s & out_ready);

   // One-cycle error pulse, one clock after an out-of-range item was accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_drop_r <= 1'b0;
      end else begin
         err_drop_r <= in_valid & in_ready & ~in_range_s;
      end
   end

   assign err_drop = err_drop_r;

`ifdef HANDSHAKE_TX_STATS_EN
   generate
      for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_stat
         logic [STAT_WIDTH-1:0] cnt_r;

         // Saturating count of handshakes completed on this channel.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_r <= {STAT_WIDTH{1'b0}};
            end else if (sel_s[c] && out_ready[c] && (cnt_r != {STAT_WIDTH{1'b1}})) begin
               cnt_r <= cnt_r + STAT_WIDTH'(1);
            end else begin
               cnt_r <= cnt_r;
            end
         end

         assign stat_ack[c*STAT_WIDTH +: STAT_WIDTH] = cnt_r;
      end
   endgenerate
`else
   assign stat_ack = {(NUM_CHANNEL*STAT_WIDTH){1'b0}};
`endif

endmodule

// File: tb/tb_handshake_channel_tx.sv
// Self-checking bench for handshake_channel_tx (3 channels, 2-bit ack counters).
// The reference model is a FIFO queue of at most two items plus per-channel
// saturating counts; expected pins are derived from the queue contents.
module tb_handshake_channel_tx;

   localparam int DW = 32;
   localparam int NC = 3;
   localparam int SW = 2;
   localparam int CW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [DW-1:0]  in_data;
   logic [CW-1:0]  in_channel;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  out_data;
   logic [NC-1:0]  out_valid;
   logic [NC-1:0]  out_ready;
   logic           err_drop;
   logic [NC*SW-1:0] stat_ack;

   typedef struct {
      logic [DW-1:0] data;
      int            ch;
   } item_t;

   item_t q[$];
   int    stat_m[NC];
   bit    err_m;
   int    n_assert = 0;
   int    n_fail   = 0;

   handshake_channel_tx #(
      .DATA_WIDTH  (DW),
      .NUM_CHANNEL (NC),
      .STAT_WIDTH  (SW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_channel (in_channel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_drop   (err_drop),
      .stat_ack   (stat_ack)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [NC-1:0]    ov_e;
      logic [NC*SW-1:0] st_e;
      ov_e = '0;
      if (q.size() > 0) ov_e[q[0].ch] = 1'b1;
      st_e = '0;
`ifdef HANDSHAKE_TX_STATS_EN
      for (int c = 0; c < NC; c++) st_e[c*SW +: SW] = SW'(stat_m[c]);
`endif
      chk({tag, ":in_ready"}, 64'(in_ready), 64'(q.size() < 2));
      chk({tag, ":out_valid"}, 64'(out_valid), 64'(ov_e));
      if (q.size() > 0) chk({tag, ":out_data"}, 64'(out_data), 64'(q[0].data));
      chk({tag, ":err_drop"}, 64'(err_drop), 64'(err_m));
      chk({tag, ":stat_ack"}, 64'(stat_ack), 64'(st_e));
   endtask

   task automatic drive(input bit v, input int ch, input logic [DW-1:0] d, input logic [NC-1:0] r);
      in_valid   = v;
      in_channel = CW'(ch);
      in_data    = d;
      out_ready  = r;
   endtask

   // Advance one clock: predict the handshakes from the model, then compare.
   task automatic step(input string tag);
      bit            ack;
      bit            acc;
      int            hc;
      logic [DW-1:0] d;
      ack = (q.size() > 0) && (out_ready[q[0].ch] == 1'b1);
      acc = (in_valid == 1'b1) && (q.size() < 2);
      hc  = int'(in_channel);
      d   = in_data;
      @(posedge clk);
      #1;
      if (ack) begin
         if (stat_m[q[0].ch] < (1 << SW) - 1) stat_m[q[0].ch]++;
         void'(q.pop_front());
      end
      err_m = acc && (hc >= NC);
      if (acc && (hc < NC)) q.push_back('{d, hc});
      check_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      for (int c = 0; c < NC; c++) stat_m[c] = 0;
      err_m = 1'b0;
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      drive(1'b0, 0, 32'h0, 3'b000);
      #12;
      check_all("reset");
      chk("reset:out_data", 64'(out_data), 64'h0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back items over every channel, all consumers ready.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, i % NC, 32'h1000 + 32'(i), 3'b111);
         step("b2b");
      end
      drive(1'b0, 0, 32'h0, 3'b111);
      step("b2b_drain");

      // Single item on ch2: other ready bits must not retire it.
      drive(1'b1, 2, 32'hA5A5_0002, 3'b011);
      step("hold_push");
      drive(1'b0, 0, 32'h0, 3'b011);
      for (int i = 0; i < 4; i++) step("hold");
      drive(1'b0, 0, 32'h0, 3'b100);
      step("hold_ack");
      step("hold_idle");

      // Stalled consumers: two items fill the buffer, the third waits.
      drive(1'b1, 0, 32'h0000_0031, 3'b000);
      step("full1");
      drive(1'b1, 1, 32'h0000_0032, 3'b000);
      step("full2");
      drive(1'b1, 2, 32'h0000_0033, 3'b000);
      step("full3");
      step("full3b");
      drive(1'b1, 2, 32'h0000_0033, 3'b111);
      step("drain1");
      drive(1'b0, 0, 32'h0, 3'b111);
      for (int i = 0; i < 3; i++) step("drain");

      // Out-of-range channel: accepted, dropped, error pulse.
      drive(1'b1, 3, 32'h0000_DEAD, 3'b111);
      step("oor");
      drive(1'b0, 0, 32'h0, 3'b111);
      step("oor_after");

      // Asynchronous reset while the buffer is full.
      drive(1'b1, 1, 32'h0000_0041, 3'b000);
      step("rst_fill1");
      drive(1'b1, 2, 32'h0000_0042, 3'b000);
      step("rst_fill2");
      drive(1'b0, 0, 32'h0, 3'b000);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 1, 32'h0000_0051, 3'b000);
      step("post_rst");
      drive(1'b0, 0, 32'h0, 3'b010);
      step("post_rst_ack");

      // Five acks on ch1 saturate a 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1, 32'h0000_0060 + 32'(i), 3'b111);
         step("sat");
      end
      drive(1'b0, 0, 32'h0, 3'b111);
      step("sat_drain");
      step("sat_idle");

      // Randomized traffic, including out-of-range channels and partial readiness.
      for (int i = 0; i < 400; i++) begin
         logic [NC-1:0] r;
         r = NC'($urandom_range(0, 7));
         drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom, r);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
